// File: rtl/uart_pkg.sv
// Shared UART transmit definitions.
// - tx_state_e : transmit FSM states
// - Wls*       : word-length select encodings (5..8 data bits)
// - stop_ticks : length of the stop period in baud_pulse ticks
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam logic [1:0] Wls5 = 2'b00;
    localparam logic [1:0] Wls6 = 2'b01;
    localparam logic [1:0] Wls7 = 2'b10;
    localparam logic [1:0] Wls8 = 2'b11;

    // One stop bit, 1.5 stop bits for 5-bit words, 2 stop bits otherwise.
    function automatic int unsigned stop_ticks(int unsigned oversample, logic stb,
                                               logic [1:0] wls);
        if (!stb) begin
            return oversample;
        end else if (wls == Wls5) begin
            return (3 * oversample) / 2;
        end else begin
            return 2 * oversample;
        end
    endfunction

endpackage

// File: rtl/uart_tx_gen_if.sv
// Frame request channel into the UART transmitter.
// - s_valid/s_ready : request/accept handshake
// - s_data          : character, LSB sent first
// - wls/pen/eps/stick/stb : frame format, sampled together with s_data
interface uart_tx_gen_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       stick;
    logic       stb;
    logic       s_ready;

    modport master (output s_valid, s_data, wls, pen, eps, stick, stb, input s_ready);
    modport slave  (input s_valid, s_data, wls, pen, eps, stick, stb, output s_ready);
endinterface

// File: rtl/uart_parity_gen.sv
// Parity bit generator for the UART transmitter.
// - data   : character (bits above the word length are ignored)
// - wls    : word length select
// - pen    : parity enable (parity reads 1 when disabled)
// - eps    : even parity select
// - stick  : stick parity (eps chooses the constant)
// - parity : parity bit to place on the line
module uart_parity_gen
    import uart_pkg::*;
(
    input  logic [7:0] data,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       stick,
    output logic       parity
);

    logic [7:0] mask;
    logic       x;
    logic       p;

    always_comb begin
        unique case (wls)
            Wls5:    mask = 8'h1f;
            Wls6:    mask = 8'h3f;
            Wls7:    mask = 8'h7f;
            default: mask = 8'hff;
        endcase
        x = ^(data & mask);
        unique case ({stick, eps})
            2'b00:   p = ~x;
            2'b01:   p = x;
            2'b10:   p = 1'b1;
            default: p = 1'b0;
        endcase
        parity = pen ? p : 1'b1;
    end

endmodule

// File: rtl/uart_tx_gen.sv
// UART frame transmitter: start bit, 5-8 data bits LSB first, optional parity,
// 1/1.5/2 stop bits, all timed in baud_pulse ticks (OVERSAMPLE per bit).
// - clk, rst_n   : clock, asynchronous active-low reset
// - baud_pulse   : one-clk tick strobe
// - set_break    : forces the line low while asserted
// - s_if         : frame request channel (slave side)
// - tx           : registered serial line
// - busy         : frame in progress
// - frame_done   : one-clk pulse after the final stop tick
module uart_tx_gen
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         baud_pulse,
    input  logic         set_break,
    uart_tx_gen_if.slave s_if,
    output logic         tx,
    output logic         busy,
    output logic         frame_done
);

    localparam int unsigned TickW = $clog2(2 * OVERSAMPLE);
    localparam logic [TickW-1:0] BitLast = TickW'(OVERSAMPLE - 1);

    tx_state_e        state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic             done_q, done_d;
    logic             tx_q;

    logic [7:0]       data_q;
    logic [1:0]       wls_q;
    logic             pen_q, eps_q, stick_q, stb_q;

    logic             s_ready;
    logic             accept;
    logic             line_bit;
    logic             parity_bit;
    logic [2:0]       data_last;
    logic [TickW-1:0] stop_last;

    assign accept    = s_if.s_valid & s_ready;
    assign data_last = 3'd4 + {1'b0, wls_q};
    assign stop_last = TickW'(stop_ticks(OVERSAMPLE, stb_q, wls_q) - 1);

    uart_parity_gen u_parity (
        .data   (data_q),
        .wls    (wls_q),
        .pen    (pen_q),
        .eps    (eps_q),
        .stick  (stick_q),
        .parity (parity_bit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
        end
    end

    // Frame format is captured on accept so mid-frame input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            wls_q   <= Wls5;
            pen_q   <= 1'b0;
            eps_q   <= 1'b0;
            stick_q <= 1'b0;
            stb_q   <= 1'b0;
        end else if (accept) begin
            data_q  <= s_if.s_data;
            wls_q   <= s_if.wls;
            pen_q   <= s_if.pen;
            eps_q   <= s_if.eps;
            stick_q <= s_if.stick;
            stb_q   <= s_if.stb;
        end
    end

    // Next-state logic; counters move only on baud_pulse.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s_if.s_valid) begin
                    state_d = StStart;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            StStart: begin
                if (baud_pulse) begin
                    if (tick_q == BitLast) begin
                        state_d = StData;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
            end
            StData: begin
                if (baud_pulse) begin
                    if (tick_q == BitLast) begin
                        tick_d = '0;
                        if (bit_q == data_last) begin
                            bit_d   = '0;
                            state_d = pen_q ? StParity : StStop;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
            end
            StParity: begin
                if (baud_pulse) begin
                    if (tick_q == BitLast) begin
                        state_d = StStop;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
            end
            StStop: begin
                if (baud_pulse) begin
                    if (tick_q == stop_last) begin
                        state_d = StIdle;
                        tick_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode
    always_comb begin
        s_ready = (state_q == StIdle);
        unique case (state_q)
            StStart:  line_bit = 1'b0;
            StData:   line_bit = data_q[bit_q];
            StParity: line_bit = parity_bit;
            default:  line_bit = 1'b1;
        endcase
    end

    // Break is applied at the output only, so frame timing is untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= 1'b1;
        end else begin
            tx_q <= line_bit & ~set_break;
        end
    end

    assign s_if.s_ready = s_ready;
    assign busy         = ~s_ready;
    assign tx           = tx_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_uart_tx_gen.sv
module tb_uart_tx_gen;

    localparam int unsigned OS = 16;

    typedef struct {
        logic [7:0] data;
        logic [1:0] wls;
        logic       pen;
        logic       eps;
        logic       stick;
        logic       stb;
        logic       exp_par;
        int         exp_stop;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic baud_pulse;
    logic set_break;
    logic tx;
    logic busy;
    logic frame_done;

    uart_tx_gen_if bus ();

    uart_tx_gen #(
        .OVERSAMPLE (OS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_pulse (baud_pulse),
        .set_break  (set_break),
        .s_if       (bus),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic trace [256];
    int   npulse;
    bit   baud_en  = 1'b0;
    int   bcnt     = 0;
    vec_t vecs [10];

    // One baud_pulse every third clk while enabled, driven on the falling edge.
    initial begin
        baud_pulse = 1'b0;
        forever begin
            @(negedge clk);
            bcnt = (bcnt == 2) ? 0 : bcnt + 1;
            baud_pulse = baud_en && (bcnt == 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic [7:0] d, logic [1:0] w, logic p, logic e, logic s,
                                logic sb, logic ep, int st);
        vec_t v;
        v.data = d; v.wls = w; v.pen = p; v.eps = e; v.stick = s; v.stb = sb;
        v.exp_par = ep; v.exp_stop = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        bus.s_data = v.data; bus.wls = v.wls; bus.pen = v.pen;
        bus.eps = v.eps; bus.stick = v.stick; bus.stb = v.stb;
    endtask

    task automatic scramble(input vec_t v);
        bus.s_data = ~v.data; bus.wls = ~v.wls; bus.pen = ~v.pen;
        bus.eps = ~v.eps; bus.stick = ~v.stick; bus.stb = ~v.stb;
    endtask

    // Leaves the bench on the falling edge right after the accepting clk.
    task automatic drive_frame(input vec_t v, input bit hold, input string tag);
        bit ok = 1'b0;
        @(negedge clk);
        set_inputs(v);
        bus.s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.s_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check({tag, "-accept-timeout"}, 0, 1);
        @(negedge clk);
        if (!hold) begin
            bus.s_valid = 1'b0;
            scramble(v);
        end
    endtask

    // trace[k] holds tx after the k-th baud tick, i.e. the line value of that tick.
    task automatic capture(output int done_at);
        logic p;
        npulse  = 0;
        done_at = -1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            p = baud_pulse;
            @(negedge clk);
            if (p) begin
                if (npulse < 256) trace[npulse] = tx;
                npulse++;
            end
            if (frame_done === 1'b1) begin
                done_at = npulse;
                break;
            end
        end
    endtask

    task automatic score(input vec_t v, input int done_at, input string tag);
        int         nb;
        int         nseg;
        int         total;
        int         bad;
        logic [11:0] exp_pat;
        logic [11:0] act_pat;
        logic        e;
        nb    = 5 + int'(v.wls);
        nseg  = 1 + nb + int'(v.pen);
        total = OS * nseg + v.exp_stop;
        check({tag, "-done-tick"}, done_at, total);
        exp_pat = '0;
        for (int i = 0; i < nb; i++) exp_pat[1+i] = v.data[i];
        if (v.pen) exp_pat[1+nb] = v.exp_par;
        act_pat = '0;
        for (int s = 0; s < nseg; s++) act_pat[s] = trace[s*OS + OS/2];
        check({tag, "-bits"}, act_pat, exp_pat);
        bad = 0;
        for (int k = 0; k < total && k < npulse && k < 256; k++) begin
            e = (k / OS < nseg) ? exp_pat[k/OS] : 1'b1;
            if (trace[k] !== e) bad++;
        end
        check({tag, "-tick-errors"}, bad, 0);
        @(negedge clk);
        check({tag, "-done-width"}, frame_done, 0);
    endtask

    initial begin
        int   d;
        int   d2;
        int   bad;
        vec_t v;

        vecs[0] = mk(8'ha5, 2'b11, 0, 0, 0, 0, 0, 16);
        vecs[1] = mk(8'h41, 2'b10, 1, 1, 0, 0, 0, 16);
        vecs[2] = mk(8'h1f, 2'b00, 0, 0, 0, 1, 0, 24);
        vecs[3] = mk(8'h3c, 2'b11, 0, 0, 0, 1, 0, 32);
        vecs[4] = mk(8'h03, 2'b11, 1, 0, 0, 0, 1, 16);
        vecs[5] = mk(8'hff, 2'b01, 1, 0, 1, 0, 1, 16);
        vecs[6] = mk(8'h00, 2'b00, 1, 1, 1, 1, 0, 24);
        vecs[7] = mk(8'he0, 2'b00, 1, 1, 0, 0, 0, 16);
        vecs[8] = mk(8'h80, 2'b10, 1, 0, 0, 0, 1, 16);
        vecs[9] = mk(8'h2a, 2'b01, 0, 0, 0, 1, 0, 32);

        rst_n = 1'b0;
        set_break = 1'b0;
        bus.s_valid = 1'b0;
        set_inputs(vecs[0]);
        repeat (3) @(negedge clk);
        check("reset-tx", tx, 1);
        check("reset-s_ready", bus.s_ready, 1);
        check("reset-busy", busy, 0);
        check("reset-frame_done", frame_done, 0);
        rst_n   = 1'b1;
        baud_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive_frame(vecs[i], 1'b0, $sformatf("vec%0d", i));
            capture(d);
            score(vecs[i], d, $sformatf("vec%0d", i));
        end

        // No baud_pulse: the frame must not advance.
        baud_en = 1'b0;
        repeat (4) @(negedge clk);
        drive_frame(vecs[0], 1'b0, "hold");
        repeat (30) @(negedge clk);
        check("hold-busy", busy, 1);
        check("hold-tx", tx, 0);
        baud_en = 1'b1;
        capture(d);
        score(vecs[0], d, "hold");

        // Held s_valid: second frame follows immediately with the wls seen then.
        drive_frame(vecs[0], 1'b1, "b2b1");
        fork
            capture(d);
            begin
                repeat (100) @(negedge clk);
                bus.wls = 2'b00;
            end
        join
        score(vecs[0], d, "b2b1");
        check("b2b-reaccept-busy", busy, 1);
        bus.s_valid = 1'b0;
        capture(d2);
        v = mk(8'ha5, 2'b00, 0, 0, 0, 0, 0, 16);
        score(v, d2, "b2b2");

        // Break during data.
        v = mk(8'hff, 2'b11, 0, 0, 0, 0, 0, 16);
        bad = 0;
        drive_frame(v, 1'b0, "brk");
        fork
            capture(d);
            begin
                repeat (60) @(negedge clk);
                set_break = 1'b1;
                repeat (30) begin
                    @(negedge clk);
                    if (tx !== 1'b0) bad++;
                end
                set_break = 1'b0;
            end
        join
        check("brk-tx-low", bad, 0);
        check("brk-done-tick", d, 160);
        check("brk-last-data-bit", trace[OS*8 + OS/2], 1);
        check("brk-stop", trace[159], 1);

        // Reset mid-data, then a clean frame accepted on the first clk.
        v = mk(8'h5a, 2'b11, 0, 0, 0, 0, 0, 16);
        drive_frame(v, 1'b0, "rst");
        repeat (80) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst-tx", tx, 1);
        check("rst-s_ready", bus.s_ready, 1);
        check("rst-busy", busy, 0);
        check("rst-frame_done", frame_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_inputs(vecs[1]);
        bus.s_valid = 1'b1;
        @(negedge clk);
        check("rst-first-accept", busy, 1);
        bus.s_valid = 1'b0;
        scramble(vecs[1]);
        capture(d);
        score(vecs[1], d, "rst-after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
